// File: rtl/display_pkg.sv
// Shared types and helpers for the 3-digit, 7-segment multiplexed display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned NUM_SEGS   = 7;
  localparam int unsigned DIG_W      = 2;
  localparam int unsigned PAT_W      = NUM_SEGS * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SLOT  = 2'd2
  } scan_state_e;

  typedef logic [DIG_W-1:0] digit_t;

  // Pattern layout: [segment][digit], segment A in the low field, bit d lights digit d.
  typedef logic [NUM_SEGS-1:0][NUM_DIGITS-1:0] pattern_t;

  function automatic pattern_t rotate_left(input pattern_t p);
    pattern_t r;
    for (int s = 0; s < NUM_SEGS; s++) begin
      r[s] = {p[s][NUM_DIGITS-2:0], p[s][NUM_DIGITS-1]};
    end
    return r;
  endfunction

  function automatic logic [NUM_SEGS-1:0] segs_for_digit(input pattern_t p, input digit_t d);
    logic [NUM_SEGS-1:0] r;
    r = '0;
    for (int s = 0; s < NUM_SEGS; s++) begin
      r[s] = p[s][d];
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter; flags register "count is 0" and "count is 1" for the following cycle.
module slot_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o,
  output logic         near_tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, near_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tc_q   <= 1'b1;
      near_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= (cnt_d == '0);
      near_q <= (cnt_d == W'(1));
    end
  end

  assign tc_o      = tc_q;
  assign near_tc_o = near_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 3-digit display scanner with blanking gaps, double-buffered pattern load
// applied only at frame boundaries, and optional periodic pattern rotation.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned ROT_SCANS = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [PAT_W-1:0]      load_data,
  input  logic                  rot_en,
  output logic [NUM_SEGS-1:0]   oSeg,
  output logic [NUM_DIGITS-1:0] oDig,
  output logic                  frame_done
);

  localparam int unsigned TMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned RW   = (ROT_SCANS > 1) ? $clog2(ROT_SCANS) : 1;
  localparam digit_t LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  digit_t                digit_q, digit_d;
  pattern_t              active_q, active_d;
  pattern_t              pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic [RW-1:0]         rot_cnt_q, rot_cnt_d;
  logic [NUM_SEGS-1:0]   seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_ready_q, load_ready_d;

  logic                  tmr_load_c;
  logic [TW-1:0]         tmr_val_c;
  logic                  tmr_tc, tmr_near;
  logic                  accept_c, xfer_c, rot_wrap_c;

  slot_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .tc_o       (tmr_tc),
    .near_tc_o  (tmr_near)
  );

  // Scan sequencing: IDLE -> BLANK -> SLOT -> BLANK ... with the digit advancing per slot.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    if (!enable) begin
      state_d    = ST_IDLE;
      digit_d    = '0;
      tmr_load_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_BLANK;
          tmr_load_c = 1'b1;
          tmr_val_c  = TW'(BLANK_CYC - 1);
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_d    = ST_SLOT;
            tmr_load_c = 1'b1;
            tmr_val_c  = TW'(CLK_DIV - 1);
          end
        end
        ST_SLOT: begin
          if (tmr_tc) begin
            state_d    = ST_BLANK;
            digit_d    = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
            tmr_load_c = 1'b1;
            tmr_val_c  = TW'(BLANK_CYC - 1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Raised one cycle early so the registered pulse lands on the final digit-2 slot cycle.
    frame_done_d = enable && (state_q == ST_SLOT) && (digit_q == LAST_DIGIT) && tmr_near;
  end

  // Pattern buffering, rotation, and registered display outputs.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    rot_cnt_d      = rot_cnt_q;
    accept_c       = load_valid && load_ready_q;
    xfer_c         = pending_full_q && (frame_done_q || (state_q == ST_IDLE));
    rot_wrap_c     = (rot_cnt_q == RW'(ROT_SCANS - 1));

    if (xfer_c) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept_c) begin
      pending_d      = pattern_t'(load_data);
      pending_full_d = 1'b1;
    end

    if (!rot_en) begin
      rot_cnt_d = '0;
    end else if (frame_done_q) begin
      if (xfer_c || rot_wrap_c) begin
        rot_cnt_d = '0;
      end else begin
        rot_cnt_d = rot_cnt_q + RW'(1);
      end
      if (!xfer_c && rot_wrap_c) begin
        active_d = rotate_left(active_q);
      end
    end

    load_ready_d = !pending_full_d;
    dig_d        = '1;
    seg_d        = '0;
    if (state_d == ST_SLOT) begin
      dig_d = ~(NUM_DIGITS'(1) << digit_d);
      seg_d = segs_for_digit(active_d, digit_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      digit_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      rot_cnt_q      <= '0;
      seg_q          <= '0;
      dig_q          <= '1;
      frame_done_q   <= 1'b0;
      load_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      digit_q        <= digit_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      rot_cnt_q      <= rot_cnt_d;
      seg_q          <= seg_d;
      dig_q          <= dig_d;
      frame_done_q   <= frame_done_d;
      load_ready_q   <= load_ready_d;
    end
  end

  assign oSeg       = seg_q;
  assign oDig       = dig_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=4, BLANK_CYC=2, ROT_SCANS=2 (18-cycle frames).
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [20:0] load_data;
  logic        rot_en;
  logic [6:0]  oSeg;
  logic [2:0]  oDig;
  logic        frame_done;

  int checks;
  int errors;

  typedef struct {
    logic [2:0] dig;   // expected oDig
    int         dsel;  // which digit's segment value is shown; 3 = blank
    logic       fd;    // expected frame_done
  } row_t;

  row_t tbl [18];

  display_scan_ctrl #(
    .CLK_DIV   (4),
    .BLANK_CYC (2),
    .ROT_SCANS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .rot_en     (rot_en),
    .oSeg       (oSeg),
    .oDig       (oDig),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input logic [2:0] edig, input logic [6:0] eseg, input logic efd,
                           input logic elr, input string tag);
    check({tag, " oDig"},       32'(oDig),       32'(edig));
    check({tag, " oSeg"},       32'(oSeg),       32'(eseg));
    check({tag, " frame_done"}, 32'(frame_done), 32'(efd));
    check({tag, " load_ready"}, 32'(load_ready), 32'(elr));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run n rows of the frame template; optionally offer a load on row load_row.
  task automatic run_rows(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                          input int n, input int load_row, input logic [20:0] ldata,
                          input string tag);
    logic [6:0] es;
    logic       elr;
    for (int k = 0; k < n; k++) begin
      load_valid = (k == load_row);
      load_data  = ldata;
      step();
      load_valid = 1'b0;
      case (tbl[k].dsel)
        0:       es = s0;
        1:       es = s1;
        2:       es = s2;
        default: es = 7'h00;
      endcase
      elr = (load_row >= 0 && k >= load_row) ? 1'b0 : 1'b1;
      check_out(tbl[k].dig, es, tbl[k].fd, elr, $sformatf("%s r%0d", tag, k));
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    rot_en     = 1'b0;

    // Frame template: per digit slot, 2 blank rows then 4 lit rows.
    for (int k = 0; k < 18; k++) begin
      if ((k % 6) < 2) begin
        tbl[k].dig  = 3'b111;
        tbl[k].dsel = 3;
      end else begin
        tbl[k].dsel = k / 6;
        tbl[k].dig  = (k / 6 == 0) ? 3'b110 : (k / 6 == 1) ? 3'b101 : 3'b011;
      end
      tbl[k].fd = (k == 17);
    end

    repeat (2) @(negedge clk);
    check_out(3'b111, 7'h00, 1'b0, 1'b1, "in_reset");
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      step();
      check_out(3'b111, 7'h00, 1'b0, 1'b1, $sformatf("idle c%0d", i));
    end

    // Load segA=001, segG=100 while idle; transfers on the following IDLE cycle.
    load_valid = 1'b1;
    load_data  = 21'h100001;
    step();
    load_valid = 1'b0;
    check_out(3'b111, 7'h00, 1'b0, 1'b0, "ld_accept");
    step();
    check_out(3'b111, 7'h00, 1'b0, 1'b1, "ld_idle_xfer");

    enable = 1'b1;
    run_rows(7'h01, 7'h00, 7'h40, 18, -1, 21'h0, "f1");
    run_rows(7'h01, 7'h00, 7'h40, 18, -1, 21'h0, "f2");
    run_rows(7'h01, 7'h00, 7'h40, 18, 3, 21'h1FFFFF, "f3_load");
    run_rows(7'h7F, 7'h7F, 7'h7F, 18, -1, 21'h0, "f4_new");
    run_rows(7'h7F, 7'h7F, 7'h7F, 9, -1, 21'h0, "f5_part");

    // Drop enable in the first digit-1 slot cycle.
    enable = 1'b0;
    step();
    check_out(3'b111, 7'h00, 1'b0, 1'b1, "disable");

    load_valid = 1'b1;
    load_data  = 21'h000001;
    step();
    load_valid = 1'b0;
    check_out(3'b111, 7'h00, 1'b0, 1'b0, "ld2_accept");
    step();
    check_out(3'b111, 7'h00, 1'b0, 1'b1, "ld2_xfer");

    // Re-enable with rotation: segA walks digit 0 -> 1 -> 2 -> 0 every two frames.
    rot_en = 1'b1;
    enable = 1'b1;
    run_rows(7'h01, 7'h00, 7'h00, 18, -1, 21'h0, "rot1");
    run_rows(7'h01, 7'h00, 7'h00, 18, -1, 21'h0, "rot2");
    run_rows(7'h00, 7'h01, 7'h00, 18, -1, 21'h0, "rot3");
    run_rows(7'h00, 7'h01, 7'h00, 18, -1, 21'h0, "rot4");
    run_rows(7'h00, 7'h00, 7'h01, 18, -1, 21'h0, "rot5");
    run_rows(7'h00, 7'h00, 7'h01, 18, -1, 21'h0, "rot6");
    run_rows(7'h01, 7'h00, 7'h00, 18, -1, 21'h0, "rot7");
    run_rows(7'h01, 7'h00, 7'h00, 6, 3, 21'h1FFFFF, "rot8_part");

    // Asynchronous reset mid digit-0 slot with a pending pattern held.
    #2 rst_n = 1'b0;
    #1 check_out(3'b111, 7'h00, 1'b0, 1'b1, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(7'h00, 7'h00, 7'h00, 18, -1, 21'h0, "post_rst1");
    run_rows(7'h00, 7'h00, 7'h00, 18, -1, 21'h0, "post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
